// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO hub: LED register with set/clear writes, synchronised and
// debounced switch inputs, rising-edge capture (W1C) and a masked level interrupt.
module mmio_gpio #(
  parameter int LED_W  = 24,
  parameter int SW_W   = 24,
  parameter int DB_DIV = 50000,
  parameter int ADDR_W = 5
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_ioread,
  input  logic              i_iowrite,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  input  logic [SW_W-1:0]   i_switch_in,
  output logic [LED_W-1:0]  o_led_out,
  output logic              o_irq
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int CNT_W = (DB_DIV > 2) ? $clog2(DB_DIV) : 1;

  localparam logic [IDX_W-1:0] IDX_LED    = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_LEDSET = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LEDCLR = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_SW     = IDX_W'(4);
  localparam logic [IDX_W-1:0] IDX_EDGE   = IDX_W'(5);
  localparam logic [IDX_W-1:0] IDX_MASK   = IDX_W'(6);

  logic [LED_W-1:0] r_led;
  logic [SW_W-1:0]  r_sync1;
  logic [SW_W-1:0]  r_sync2;
  logic [SW_W-1:0]  r_sample;
  logic [SW_W-1:0]  r_deb;
  logic [SW_W-1:0]  r_edge;
  logic [SW_W-1:0]  r_mask;
  logic [CNT_W-1:0] r_cnt;

  logic [IDX_W-1:0] w_idx;
  logic             w_tick;
  logic             w_wr_led;
  logic             w_wr_set;
  logic             w_wr_clr;
  logic             w_wr_edge;
  logic             w_wr_mask;
  logic [LED_W-1:0] w_wd_led;
  logic [SW_W-1:0]  w_wd_sw;
  logic [SW_W-1:0]  w_deb_next;
  logic [SW_W-1:0]  w_edge_clr;
  logic [SW_W-1:0]  w_edge_set;
  logic             w_unused;

  assign w_idx    = i_addr[ADDR_W-1:2];
  assign w_wd_led = i_wdata[LED_W-1:0];
  assign w_wd_sw  = i_wdata[SW_W-1:0];
  assign w_unused = ^{i_addr[1:0], i_wdata};

  assign w_wr_led  = i_iowrite && (w_idx == IDX_LED);
  assign w_wr_set  = i_iowrite && (w_idx == IDX_LEDSET);
  assign w_wr_clr  = i_iowrite && (w_idx == IDX_LEDCLR);
  assign w_wr_edge = i_iowrite && (w_idx == IDX_EDGE);
  assign w_wr_mask = i_iowrite && (w_idx == IDX_MASK);

  assign w_tick = (r_cnt == CNT_W'(DB_DIV - 1));

  // A bit follows the previous sample only when the new sample agrees with it.
  assign w_deb_next = w_tick ? ((r_sample & ~(r_sample ^ r_sync2)) | (r_deb & (r_sample ^ r_sync2)))
                             : r_deb;

  assign w_edge_set = w_deb_next & ~r_deb;
  assign w_edge_clr = w_wr_edge ? w_wd_sw : '0;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_sample <= '0;
      r_deb    <= '0;
    end else begin
      r_sync1 <= i_switch_in;
      r_sync2 <= r_sync1;
      r_deb   <= w_deb_next;
      if (w_tick) begin
        r_sample <= r_sync2;
      end
    end
  end

  // Set has priority over a same-cycle W1C clear.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_edge <= '0;
    end else begin
      r_edge <= (r_edge & ~w_edge_clr) | w_edge_set;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_led  <= '0;
      r_mask <= '0;
    end else begin
      if (w_wr_led) begin
        r_led <= w_wd_led;
      end else if (w_wr_set) begin
        r_led <= r_led | w_wd_led;
      end else if (w_wr_clr) begin
        r_led <= r_led & ~w_wd_led;
      end
      if (w_wr_mask) begin
        r_mask <= w_wd_sw;
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    if (i_ioread && !i_reset) begin
      case (w_idx)
        IDX_LED:  o_rdata = 32'(r_led);
        IDX_SW:   o_rdata = 32'(r_deb);
        IDX_EDGE: o_rdata = 32'(r_edge);
        IDX_MASK: o_rdata = 32'(r_mask);
        default:  o_rdata = '0;
      endcase
    end
  end

  assign o_led_out = r_led;
  assign o_irq     = |(r_edge & r_mask);

endmodule
